// File: rtl/md_hilo.sv
// md_hilo: multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/MTHI/MTLO take one edge; DIV/DIVU run a restoring divider.
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   req_valid  request present this cycle
//   req_op     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   src_a      rs operand (dividend / multiplicand / MTxx data)
//   src_b      rt operand (divisor / multiplier)
//   flush      exception/eret at commit; abort in-flight op
//   hiloren    read select [1]=HI [0]=LO
//   busy       unit cannot accept a request
//   hilordata  selected HI/LO value, 0 when nothing selected
//   hi, lo     current HI/LO registers
//
// Optional: define MD_DIV_EARLY_OUT_EN to let a divide whose
// |dividend| < |divisor| (divisor nonzero) skip the iterative phase.

module md_hilo #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic [1:0]  hiloren,
   output logic        busy,
   output logic [31:0] hilordata,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t       state;
   logic [CW-1:0] cnt;
   logic [31:0]  quo;
   logic [31:0]  rem;
   logic [31:0]  dvs;
   logic         q_neg;
   logic         r_neg;

   logic         accept;
   logic         mul_sgn;
   logic [63:0]  mul_a;
   logic [63:0]  mul_b;
   logic [63:0]  product;
   logic         div_sgn;
   logic         neg_a;
   logic         neg_b;
   logic [31:0]  abs_a;
   logic [31:0]  abs_b;
   logic [32:0]  rem_sh;
   logic         step_ge;
   logic [31:0]  rem_nxt;
   logic [31:0]  quo_nxt;
   logic [31:0]  lo_fix;
   logic [31:0]  hi_fix;

   assign busy   = (state != S_IDLE);
   assign accept = req_valid & ~busy & ~flush;

   // Sign-extend (MULT) or zero-extend (MULTU) to 64 bits; the low
   // 64 bits of the wide product are then the correct result for both.
   assign mul_sgn = (req_op == OP_MULT);
   assign mul_a   = {{32{mul_sgn & src_a[31]}}, src_a};
   assign mul_b   = {{32{mul_sgn & src_b[31]}}, src_b};
   assign product = mul_a * mul_b;

   // Magnitudes held as 32-bit unsigned: |0x80000000| is exact.
   assign div_sgn = (req_op == OP_DIV);
   assign neg_a   = div_sgn & src_a[31];
   assign neg_b   = div_sgn & src_b[31];
   assign abs_a   = neg_a ? (~src_a + 32'd1) : src_a;
   assign abs_b   = neg_b ? (~src_b + 32'd1) : src_b;

   // quo starts as the dividend and fills with quotient bits from the
   // bottom while dividend bits leave from the top into the remainder.
   assign rem_sh  = {rem, quo[31]};
   assign step_ge = (rem_sh >= {1'b0, dvs});
   // When step_ge holds the true difference is < dvs, so 32-bit
   // modular subtraction is exact.
   assign rem_nxt = step_ge ? (rem_sh[31:0] - dvs) : rem_sh[31:0];
   assign quo_nxt = {quo[30:0], step_ge};

   assign lo_fix = q_neg ? (~quo + 32'd1) : quo;
   assign hi_fix = r_neg ? (~rem + 32'd1) : rem;

   always_comb begin
      hilordata = '0;
      unique case (1'b1)
         hiloren[1]: hilordata = hi;
         hiloren[0]: hilordata = lo;
         default:    hilordata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  case (req_op)
                     OP_MULT, OP_MULTU: begin
                        hi <= product[63:32];
                        lo <= product[31:0];
                     end
                     OP_DIV, OP_DIVU: begin
                        quo   <= abs_a;
                        rem   <= '0;
                        dvs   <= abs_b;
                        q_neg <= neg_a ^ neg_b;
                        r_neg <= neg_a;
                        cnt   <= '0;
                        state <= S_RUN;
`ifdef MD_DIV_EARLY_OUT_EN
                        if ((abs_b != 32'd0) && (abs_a < abs_b)) begin
                           quo   <= '0;
                           rem   <= abs_a;
                           state <= S_FIX;
                        end
`endif
                     end
                     OP_MTHI: hi <= src_a;
                     OP_MTLO: lo <= src_a;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               lo    <= lo_fix;
               hi    <= hi_fix;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_hilo.sv
// tb_md_hilo: scoreboard bench for md_hilo.
// Expected HI/LO/busy-length pushed on drive, popped on completion.

module tb_md_hilo;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic [1:0]  hiloren;
   logic        busy;
   logic [31:0] hilordata;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   md_hilo #(.DIV_STEPS(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_op    (req_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .hiloren   (hiloren),
      .busy      (busy),
      .hilordata (hilordata),
      .hi        (hi),
      .lo        (lo)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   task automatic predict(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      exp_t        e;
      longint      pa;
      longint      pb;
      logic [63:0] p;
      int          ia;
      int          ib;
      e.cyc = 0;
      case (op)
         3'd0: begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         3'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         3'd2, 3'd3: begin
            e.cyc = 33;
            if (b == 32'd0) begin
               m_hi = a;
               m_lo = (op == 3'd2 && a[31]) ? 32'd1 : 32'hFFFFFFFF;
            end else if (op == 3'd2 && a == 32'h80000000 &&
                         b == 32'hFFFFFFFF) begin
               m_lo = 32'h80000000;
               m_hi = 32'd0;
            end else if (op == 3'd2) begin
               ia = a;
               ib = b;
               m_lo = ia / ib;
               m_hi = ia % ib;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
`ifdef MD_DIV_EARLY_OUT_EN
            if (b != 32'd0 &&
                mag(a, op == 3'd2) < mag(b, op == 3'd2))
               e.cyc = 1;
`endif
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
      e.hi = m_hi;
      e.lo = m_lo;
      sb.push_back(e);
   endtask

   task automatic finish_op(input string tag, input int n);
      exp_t e;
      e = sb.pop_front();
      chk({tag, " busy_cycles"}, 64'(n), 64'(e.cyc));
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, e.hi});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, e.lo});
   endtask

   // Request is held while busy, as a stalled upstream would.
   task automatic do_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      int n;
      predict(op, a, b);
      req_valid = 1'b1;
      req_op    = op;
      src_a     = a;
      src_b     = b;
      @(posedge clk);
      #1;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      finish_op(tag, n);
   endtask

   task automatic mf_check(input string tag);
      hiloren = 2'b01;
      #1;
      chk({tag, " mflo"}, {32'd0, hilordata}, {32'd0, m_lo});
      hiloren = 2'b10;
      #1;
      chk({tag, " mfhi"}, {32'd0, hilordata}, {32'd0, m_hi});
      hiloren = 2'b00;
      #1;
      chk({tag, " mfnone"}, {32'd0, hilordata}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n;
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      resetn    = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'd0;
      src_a     = '0;
      src_b     = '0;
      flush     = 1'b0;
      hiloren   = 2'b01;
      m_hi      = '0;
      m_lo      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset hi", {32'd0, hi}, 64'd0);
      chk("reset lo", {32'd0, lo}, 64'd0);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset rdata", {32'd0, hilordata}, 64'd0);
      hiloren = 2'b00;
      resetn  = 1'b1;

      do_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3);
      mf_check("mult");
      do_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      do_op("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2);
      do_op("divu 7/2", 3'd3, 32'd7, 32'd2);

      do_op("mthi", 3'd4, 32'h1234, 32'd0);
      do_op("mtlo", 3'd5, 32'h5678, 32'd0);

      // DIV aborted by flush in its 10th busy cycle.
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.cyc = 10;
      sb.push_back(e);
      req_valid = 1'b1;
      req_op    = 3'd2;
      src_a     = 32'hFFFFFFF9;
      src_b     = 32'd2;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (n == 10)
            flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
      end
      finish_op("flush div", n);

      // Requests presented together with flush are dropped.
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.cyc = 0;
      sb.push_back(e);
      sb.push_back(e);
      req_valid = 1'b1;
      req_op    = 3'd0;
      src_a     = 32'd9;
      src_b     = 32'd9;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      finish_op("flush mult", busy ? 1 : 0);
      req_op = 3'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      finish_op("flush divu", busy ? 1 : 0);

      do_op("nop6", 3'd6, 32'hDEAD, 32'hBEEF);
      do_op("nop7", 3'd7, 32'hDEAD, 32'hBEEF);

      do_op("mtlo aaaa", 3'd5, 32'hAAAA, 32'd0);
      do_op("div min/-1", 3'd2, 32'h80000000, 32'hFFFFFFFF);
      mf_check("div min/-1");

      do_op("div -7/0", 3'd2, 32'hFFFFFFF9, 32'd0);
      do_op("divu 5/0", 3'd3, 32'd5, 32'd0);
      do_op("divu 3/10", 3'd3, 32'd3, 32'd10);
      do_op("div -3/10", 3'd2, 32'hFFFFFFFD, 32'd10);
      do_op("div 100/-7", 3'd2, 32'd100, 32'hFFFFFFF9);

      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (i[0])
            b = b >> $urandom_range(0, 31);
         do_op($sformatf("rand%0d op%0d", i, op), op, a, b);
      end
      mf_check("final");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
